// File: rtl/reg_alu_pipe_pkg.sv
// Shared opcode encoding for the register-file/ALU execute core.
package reg_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } op_t;

endpackage

// File: rtl/reg_alu_pipe_if.sv
// Control/data bundle between the CPU controller (master) and the execute core (slave).
interface reg_alu_pipe_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             sel;
    logic             wr;
    logic [2:0]       op;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out_a;
    logic [WIDTH-1:0] d_out_b;
    logic             cout;
    logic             zero;
    logic             neg;

    modport master (
        output sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
        input  d_out_a, d_out_b, cout, zero, neg
    );

    modport slave (
        input  sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
        output d_out_a, d_out_b, cout, zero, neg
    );
endinterface

// File: rtl/reg_alu_pipe_alu.sv
// Combinational 8-operation ALU; carry semantics depend on the operation.
module alu_core
    import reg_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y,
    output logic             c
);
    logic [WIDTH:0] sum;

    always_comb begin
        sum = '0;
        y   = '0;
        c   = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                y   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
            end
            // carry out of SUB is the inverted borrow
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                y   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL: begin
                y = {a[WIDTH-2:0], 1'b0};
                c = a[WIDTH-1];
            end
            OP_SHR: begin
                y = {1'b0, a[WIDTH-1:1]};
                c = a[0];
            end
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/reg_alu_pipe.sv
// Register file + ALU with one registered write-back stage and operand bypass.
module reg_alu_pipe
    import reg_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 8,
    parameter int ZERO_R0 = 0
) (
    input logic           clk,
    input logic           reset,
    reg_alu_pipe_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] regs [NREGS];
    logic             wb_valid;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c;
    logic             cout_q;
    logic             zero_q;
    logic             neg_q;
    logic             zero_wb;

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_R0 != 0) && (addr == '0);
    endfunction

    assign zero_wb = is_zero_reg(wb_addr);

    // WB holds the youngest value, so it takes priority over the array
    always_comb begin
        rd_a = regs[bus.rd_addr_a];
        if (is_zero_reg(bus.rd_addr_a))
            rd_a = '0;
        else if (wb_valid && wb_addr == bus.rd_addr_a)
            rd_a = wb_data;
    end

    always_comb begin
        rd_b = regs[bus.rd_addr_b];
        if (is_zero_reg(bus.rd_addr_b))
            rd_b = '0;
        else if (wb_valid && wb_addr == bus.rd_addr_b)
            rd_b = wb_data;
    end

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a  (rd_a),
        .b  (rd_b),
        .op (op_t'(bus.op)),
        .y  (alu_y),
        .c  (alu_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            if (wb_valid && !zero_wb)
                regs[wb_addr] <= wb_data;
            wb_valid <= bus.wr;
            wb_addr  <= bus.wr_addr;
            wb_data  <= bus.sel ? alu_y : bus.d_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cout_q <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (bus.wr && bus.sel) begin
            cout_q <= alu_c;
            zero_q <= (alu_y == '0);
            neg_q  <= alu_y[WIDTH-1];
        end
    end

    assign bus.d_out_a = rd_a;
    assign bus.d_out_b = rd_b;
    assign bus.cout    = cout_q;
    assign bus.zero    = zero_q;
    assign bus.neg     = neg_q;
endmodule
